soc_system_pio_status_in: RTL and testbench

- Avalon-MM slave input PIO: carries FPGA-side coprocessor status (done, busy, error flags) back to the HPS.
- Complements the HPS-to-FPGA output PIOs, in the reverse direction.
- Synchronizes external status bits, captures selected edges, and raises a maskable interrupt.
- Optionally keeps a saturating edge-event counter.

---
 rtl/soc_system_pio_status_in.sv | 128 ++++++++++++
 tb/tb_soc_system_pio_status_in.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_status_in.sv
// Avalon-MM input PIO: synchronizes coprocessor status bits, captures edges, raises a maskable irq.
// Latency: in_port -> edge_capture 3 clk edges (2-flop sync + detect); readdata 1 cycle after read strobe.
// Backpressure: none; the slave always accepts, writes apply on the strobe edge, reads never stall.
//
// Parameters: WIDTH (1..32 status bits), EDGE_TYPE (0 rising, 1 falling, 2 any edge).
// Ports: clk/reset (sync, active-high); Avalon slave address/chipselect/read_n/write_n/
//        writedata/readdata; in_port (async status inputs); irq (level, to HPS).
// Register map: 0 data (RO), 1 irq_mask (RW), 2 edge_capture (W1C), 3 edge_count (RO, write clears).
// Build option: define PIO_STATUS_EDGE_COUNTER_EN to include the saturating 16-bit edge counter;
// without it address 3 reads zero and writes to it are ignored.
module soc_system_pio_status_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_1_q, sync_2_q, prev_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [1:0]       arm_q, arm_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] rise, fall, det_raw, det, w1c;
  logic             wr_en, rd_en, armed;
  logic [31:0]      count_rd;

  // writedata bits above WIDTH have no destination.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  assign wr_en = chipselect && !write_n;
  assign rd_en = chipselect && !read_n;

  assign rise    = sync_2_q & ~prev_q;
  assign fall    = ~sync_2_q & prev_q;
  assign det_raw = (EDGE_TYPE == 0) ? rise :
                   (EDGE_TYPE == 1) ? fall : (rise | fall);

  // The pipeline holds reset zeros for the first edges after reset; inputs already
  // high would look like rising edges, so detection waits until the pipe has filled.
  assign armed = (arm_q == 2'd3);
  assign det   = armed ? det_raw : '0;
  assign arm_d = armed ? arm_q : arm_q + 2'd1;

  assign w1c = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && address == 2'd1) irq_mask_d = writedata[WIDTH-1:0];
  end

  // Set has priority over a same-cycle W1C so no edge is ever lost.
  assign edge_capture_d = (edge_capture_q & ~w1c) | det;

`ifdef PIO_STATUS_EDGE_COUNTER_EN
  logic [15:0] edge_count_q, edge_count_d;

  always_comb begin
    edge_count_d = edge_count_q;
    if (wr_en && address == 2'd3) begin
      // A clear coinciding with an edge still records that edge.
      edge_count_d = {15'd0, |det};
    end else if (|det && edge_count_q != 16'hFFFF) begin
      edge_count_d = edge_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) edge_count_q <= '0;
    else       edge_count_q <= edge_count_d;
  end

  assign count_rd = {16'd0, edge_count_q};
`else
  assign count_rd = '0;
`endif

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        2'd0:    readdata_d = zext(sync_2_q);
        2'd1:    readdata_d = zext(irq_mask_q);
        2'd2:    readdata_d = zext(edge_capture_q);
        default: readdata_d = count_rd;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1_q       <= '0;
      sync_2_q       <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      arm_q          <= '0;
      readdata_q     <= '0;
    end else begin
      sync_1_q       <= in_port;
      sync_2_q       <= sync_1_q;
      prev_q         <= sync_2_q;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      arm_q          <= arm_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_status_in.sv
module tb_soc_system_pio_status_in;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
`ifdef PIO_STATUS_EDGE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in2;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Two instances share the bus: one rising-edge, one any-edge.
  soc_system_pio_status_in #(.WIDTH(8), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in0), .irq(irq0));

  soc_system_pio_status_in #(.WIDTH(8), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in2), .irq(irq2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Input history per clock edge since reset; sync_2 before edge t is the sample
  // taken at edge t-2, prev the one at t-3. Edges are honoured once 3 samples exist.
  logic [15:0] m_hist [$];
  logic [7:0]  m_mask [2];
  logic [7:0]  m_cap  [2];
  logic [31:0] m_rd   [2];
  int unsigned m_cnt  [2];

  function automatic logic [15:0] past(int k);
    if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
    return 16'h0;
  endfunction

  task automatic model_step();
    logic [15:0] dd, pp;
    logic [7:0]  d, p, det, clr;
    logic        cclr;
    if (reset) begin
      for (int e = 0; e < 2; e++) begin
        m_mask[e] = '0; m_cap[e] = '0; m_rd[e] = '0; m_cnt[e] = 0;
      end
      m_hist.delete();
    end else begin
      dd = past(2);
      pp = past(3);
      for (int e = 0; e < 2; e++) begin
        d = dd[8*e +: 8];
        p = pp[8*e +: 8];
        if (m_hist.size() < 3) det = '0;
        else if (e == 0)       det = d & ~p;
        else                   det = d ^ p;
        if (chipselect && !read_n) begin
          case (address)
            2'd0:    m_rd[e] = {24'd0, d};
            2'd1:    m_rd[e] = {24'd0, m_mask[e]};
            2'd2:    m_rd[e] = {24'd0, m_cap[e]};
            default: m_rd[e] = CNT_EN ? m_cnt[e] : 32'd0;
          endcase
        end
        clr  = '0;
        cclr = 1'b0;
        if (chipselect && !write_n) begin
          case (address)
            2'd1:    m_mask[e] = writedata[7:0];
            2'd2:    clr = writedata[7:0];
            2'd3:    cclr = 1'b1;
            default: ;
          endcase
        end
        m_cap[e] = (m_cap[e] & ~clr) | det;
        if (cclr)                              m_cnt[e] = (det != 0) ? 1 : 0;
        else if (det != 0 && m_cnt[e] < 65535) m_cnt[e] = m_cnt[e] + 1;
      end
      m_hist.push_back({in2, in0});
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
  endtask

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] a, input logic [31:0] wd);
    chipselect = (op != OP_IDLE);
    read_n     = (op != OP_RD);
    write_n    = (op != OP_WR);
    address    = a;
    writedata  = wd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  i0, i2;
    logic        chk_rd;
    logic [31:0] e_rd0, e_rd2;
    logic        e_irq0, e_irq2;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic rst, input logic [1:0] op, input logic [1:0] a,
                     input logic [31:0] wd, input logic [7:0] i0, input logic [7:0] i2,
                     input logic c, input logic [31:0] r0, input logic [31:0] r2,
                     input logic q0, input logic q2);
    vec_t v;
    v.rst = rst; v.op = op; v.addr = a; v.wdata = wd; v.i0 = i0; v.i2 = i2;
    v.chk_rd = c; v.e_rd0 = r0; v.e_rd2 = r2; v.e_irq0 = q0; v.e_irq2 = q2;
    tbl.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_cnt;
    reset = 1'b1;
    in0 = '0; in2 = '0;
    drive(OP_IDLE, 2'd0, 32'd0);
    @(negedge clk);

    // Reset state: every register reads zero, irq low.
    repeat (3) cyc();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      drive(OP_RD, a[1:0], 32'd0);
      cyc();
      chk($sformatf("reset_rd0_a%0d", a), rd0, 32'd0);
      chk($sformatf("reset_rd2_a%0d", a), rd2, 32'd0);
      chk($sformatf("reset_irq_a%0d", a), {30'd0, irq2, irq0}, 32'd0);
    end

    // Inputs held high through reset must not be captured.
    in0 = 8'hFF; in2 = 8'hFF;
    drive(OP_IDLE, 2'd0, 32'd0);
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    drive(OP_RD, 2'd2, 32'd0);
    cyc();
    chk("held_high_cap0", rd0, 32'd0);
    chk("held_high_cap2", rd2, 32'd0);
    chk("held_high_irq", {30'd0, irq2, irq0}, 32'd0);

    // Directed table: one row per clock edge, expectations sampled after that edge.
    exp_cnt = CNT_EN ? 32'd3 : 32'd0;
    add(1, OP_IDLE, 0, 0,            8'h00, 8'h00, 1, 0, 0, 0, 0); // e0 reset
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_WR,   1, 32'h01,       8'h00, 8'h00, 0, 0, 0, 0, 0); // e4 mask=01
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 0, 0); // e5 bit0 rises
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_RD,   2, 0,            8'h01, 8'h00, 1, 0, 0, 1, 0); // e7 set; read sees old
    add(0, OP_RD,   2, 0,            8'h01, 8'h00, 1, 1, 0, 1, 0);
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 1, 0); // e9 fall (ignored)
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 1, 0);
    add(0, OP_IDLE, 0, 0,            8'h00, 8'h00, 0, 0, 0, 1, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 1, 0); // e12 rise again
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 1, 0);
    add(0, OP_WR,   2, 32'h01,       8'h01, 8'h00, 0, 0, 0, 1, 0); // e14 W1C vs set
    add(0, OP_RD,   2, 0,            8'h01, 8'h00, 1, 1, 0, 1, 0);
    add(0, OP_WR,   2, 32'h01,       8'h01, 8'h00, 0, 0, 0, 0, 0); // e16 W1C clears
    add(0, OP_RD,   2, 0,            8'h01, 8'h00, 1, 0, 0, 0, 0);
    add(0, OP_WR,   1, 32'h00,       8'h01, 8'h00, 0, 0, 0, 0, 0); // e18 mask=0
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h08, 0, 0, 0, 0, 0); // e19 bit3 up
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h08, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h08, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h08, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h08, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 0, 0); // e24 bit3 down
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_IDLE, 0, 0,            8'h01, 8'h00, 0, 0, 0, 0, 0);
    add(0, OP_RD,   2, 0,            8'h01, 8'h00, 1, 0, 32'h08, 0, 0);
    add(0, OP_WR,   1, 32'h08,       8'h01, 8'h00, 0, 0, 0, 0, 1); // e28 mask=08
    add(0, OP_RD,   1, 0,            8'h01, 8'h00, 1, 32'h08, 32'h08, 0, 1);
    add(0, OP_IDLE, 0, 0,            8'hA5, 8'hA5, 0, 0, 0, 0, 1); // e30 A5
    add(0, OP_IDLE, 0, 0,            8'hA5, 8'hA5, 0, 0, 0, 0, 1);
    add(0, OP_IDLE, 0, 0,            8'hA5, 8'hA5, 1, 32'h08, 32'h08, 0, 1); // held
    add(0, OP_RD,   0, 0,            8'hA5, 8'hA5, 1, 32'hA5, 32'hA5, 0, 1);
    add(0, OP_RD,   2, 0,            8'hA5, 8'hA5, 1, 32'hA4, 32'hAD, 0, 1);
    add(0, OP_RD,   3, 0,            8'hA5, 8'hA5, 1, exp_cnt, exp_cnt, 0, 1);
    add(0, OP_WR,   0, 32'hFFFFFFFF, 8'hA5, 8'hA5, 0, 0, 0, 0, 1);
    add(0, OP_RD,   0, 0,            8'hA5, 8'hA5, 1, 32'hA5, 32'hA5, 0, 1);
    add(0, OP_WR,   1, 32'hFFFFFF00, 8'hA5, 8'hA5, 0, 0, 0, 0, 0); // mask cleared
    add(0, OP_RD,   1, 0,            8'hA5, 8'hA5, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      in0   = tbl[i].i0;
      in2   = tbl[i].i2;
      drive(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      cyc();
      if (tbl[i].chk_rd) begin
        chk($sformatf("tbl%0d_rd0", i), rd0, tbl[i].e_rd0);
        chk($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e_rd2);
      end
      chk($sformatf("tbl%0d_irq0", i), {31'd0, irq0}, {31'd0, tbl[i].e_irq0});
      chk($sformatf("tbl%0d_irq2", i), {31'd0, irq2}, {31'd0, tbl[i].e_irq2});
    end

    // Randomized traffic against the model, with occasional mid-run resets.
    reset = 1'b1;
    drive(OP_IDLE, 2'd0, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 3) == 0) in0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) in2 = 8'($urandom);
      drive(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), $urandom);
      cyc();
      chk($sformatf("rnd%0d_rd0", i), rd0, m_rd[0]);
      chk($sformatf("rnd%0d_rd2", i), rd2, m_rd[1]);
      chk($sformatf("rnd%0d_irq0", i), {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
      chk($sformatf("rnd%0d_irq2", i), {31'd0, irq2}, {31'd0, |(m_cap[1] & m_mask[1])});
    end

`ifdef PIO_STATUS_EDGE_COUNTER_EN
    // Saturation: alternating 55/AA gives a detected edge every cycle.
    in0 = '0; in2 = '0;
    reset = 1'b1;
    drive(OP_IDLE, 2'd0, 32'd0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 65600; i++) begin
      in0 = i[0] ? 8'hAA : 8'h55;
      in2 = in0;
      cyc();
    end
    in0 = '0; in2 = '0;
    repeat (5) cyc();
    drive(OP_RD, 2'd3, 32'd0);
    cyc();
    chk("cnt_sat0", rd0, 32'h0000FFFF);
    chk("cnt_sat2", rd2, 32'h0000FFFF);

    // Clear coinciding with an edge leaves the count at 1.
    in0 = 8'h01; in2 = 8'h01;
    drive(OP_IDLE, 2'd0, 32'd0);
    cyc();
    cyc();
    drive(OP_WR, 2'd3, 32'd0);
    cyc();
    drive(OP_RD, 2'd3, 32'd0);
    cyc();
    chk("cnt_clr_edge0", rd0, 32'd1);
    chk("cnt_clr_edge2", rd2, 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
